// File: rtl/hamming_pkg.sv
// Shared widths and FSM state type for the serial Hamming(7,4) receiver.
package hamming_pkg;

   localparam int unsigned CW_W   = 7;
   localparam int unsigned DATA_W = 4;
   localparam int unsigned SYN_W  = 3;
   localparam int unsigned POS_W  = 3;

   typedef enum logic {
      IDLE = 1'b0,
      RECV = 1'b1
   } rx_state_t;

endpackage

// File: rtl/hamming_correct.sv
// Combinational Hamming(7,4) syndrome, single-bit correction and data extraction.
// Codeword layout: c0=p1, c1=p2, c2=d0, c3=p4, c4=d1, c5=d2, c6=d3.
module hamming_correct
   import hamming_pkg::*;
(
   input  logic [CW_W-1:0]   cw,
   output logic [DATA_W-1:0] data_c,
   output logic [SYN_W-1:0]  syn_c,
   output logic              corr_c
);

   // Syndrome k points at bit c(k-1); only data positions 3,5,6,7 affect the nibble.
   always_comb begin
      syn_c  = {cw[3] ^ cw[4] ^ cw[5] ^ cw[6],
                cw[1] ^ cw[2] ^ cw[5] ^ cw[6],
                cw[0] ^ cw[2] ^ cw[4] ^ cw[6]};
      corr_c = |syn_c;
      data_c = {cw[6] ^ (syn_c == SYN_W'(7)),
                cw[5] ^ (syn_c == SYN_W'(6)),
                cw[4] ^ (syn_c == SYN_W'(5)),
                cw[2] ^ (syn_c == SYN_W'(3))};
   end

endmodule

// File: rtl/hamming_serial_rx.sv
// Serial Hamming(7,4) receiver: assembles LSB-first codewords, corrects single
// bit errors and presents the nibble through a one-entry valid/ready register.
module hamming_serial_rx
   import hamming_pkg::*;
#(
   parameter int unsigned CNT_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ena,
   input  logic              bit_in,
   input  logic              bit_valid,
   input  logic              sync,
   output logic [DATA_W-1:0] data_out,
   output logic              data_valid,
   input  logic              data_ready,
   output logic              err_corr,
   output logic [SYN_W-1:0]  err_syn,
   output logic [CNT_W-1:0]  err_cnt,
   output logic              overrun
);

   localparam logic [POS_W-1:0] LAST_POS = POS_W'(CW_W - 1);

   rx_state_t          state, state_n;
   logic [POS_W-1:0]   count, count_n;
   logic [CW_W-1:0]    sr, sr_n;
   logic               complete_c;
   logic [DATA_W-1:0]  fix_data_c;
   logic [SYN_W-1:0]   fix_syn_c;
   logic               fix_corr_c;
   logic               handshake_c;
   logic               load_c;

   // Framing state, bit position and assembly register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         count <= '0;
         sr    <= '0;
      end else begin
         state <= state_n;
         count <= count_n;
         sr    <= sr_n;
      end
   end

   // Next-state: sync always restarts a frame; the 7th bit completes and re-arms RECV.
   always_comb begin
      state_n    = state;
      count_n    = count;
      sr_n       = sr;
      complete_c = 1'b0;
      if (!ena) begin
         state_n = IDLE;
         count_n = '0;
      end else if (bit_valid) begin
         if (sync) begin
            sr_n[0] = bit_in;
            count_n = POS_W'(1);
            state_n = RECV;
         end else if (state == RECV) begin
            for (int i = 0; i < int'(CW_W); i++) begin
               if (count == POS_W'(i)) sr_n[i] = bit_in;
            end
            if (count == LAST_POS) begin
               count_n    = '0;
               complete_c = 1'b1;
            end else begin
               count_n = count + POS_W'(1);
            end
         end
      end
   end

   // The completing bit is already merged into sr_n, so correct that word directly.
   hamming_correct u_correct (
      .cw     (sr_n),
      .data_c (fix_data_c),
      .syn_c  (fix_syn_c),
      .corr_c (fix_corr_c)
   );

   assign handshake_c = data_valid & data_ready;
   assign load_c      = complete_c & (~data_valid | data_ready);

   // One-entry output register with error statistics and sticky overrun.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_out   <= '0;
         data_valid <= 1'b0;
         err_corr   <= 1'b0;
         err_syn    <= '0;
         err_cnt    <= '0;
         overrun    <= 1'b0;
      end else if (load_c) begin
         data_out   <= fix_data_c;
         err_syn    <= fix_syn_c;
         err_corr   <= fix_corr_c;
         data_valid <= 1'b1;
         if (fix_corr_c && (err_cnt != {CNT_W{1'b1}})) begin
            err_cnt <= err_cnt + CNT_W'(1);
         end
      end else if (complete_c) begin
         overrun <= 1'b1;
      end else if (handshake_c) begin
         data_valid <= 1'b0;
      end
   end

endmodule
